// File: rtl/axi4_lite_regfile_slave_if.sv
// AXI4-Lite bus bundle for the register file slave.
// Ports: AW/W/B/AR/R channel signals; master and slave modports.
interface axi4_lite_regfile_slave_if #(
    parameter int ADDR_BYTES = 1,
    parameter int DATA_BYTES = 4
);
    logic                      awvalid;
    logic                      awready;
    logic [ADDR_BYTES*8-1:0]   awaddr;
    logic [2:0]                awprot;
    logic                      wvalid;
    logic                      wready;
    logic [DATA_BYTES*8-1:0]   wdata;
    logic [DATA_BYTES-1:0]     wstrb;
    logic                      bvalid;
    logic                      bready;
    logic [1:0]                bresp;
    logic                      arvalid;
    logic                      arready;
    logic [ADDR_BYTES*8-1:0]   araddr;
    logic [2:0]                arprot;
    logic                      rvalid;
    logic                      rready;
    logic [DATA_BYTES*8-1:0]   rdata;
    logic [1:0]                rresp;

    modport master (
        output awvalid, awaddr, awprot,
        output wvalid, wdata, wstrb,
        output bready,
        output arvalid, araddr, arprot,
        output rready,
        input  awready, wready,
        input  bvalid, bresp,
        input  arready,
        input  rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot,
        input  wvalid, wdata, wstrb,
        input  bready,
        input  arvalid, araddr, arprot,
        input  rready,
        output awready, wready,
        output bvalid, bresp,
        output arready,
        output rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi4_lite_regfile_slave.sv
// AXI4-Lite slave holding NUM_REGS word registers with byte strobes.
// Ports: aclk, aresetn, bus (slave modport), reg_q (flat contents), wr_pulse (per-reg commit).
module axi4_lite_regfile_slave #(
    parameter int DATA_BYTES = 4,
    parameter int ADDR_BYTES = 1,
    parameter int NUM_REGS   = 16,
    parameter logic [DATA_BYTES*8-1:0] RESET_VALUE = '0
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    axi4_lite_regfile_slave_if.slave         bus,
    output logic [NUM_REGS*DATA_BYTES*8-1:0] reg_q,
    output logic [NUM_REGS-1:0]              wr_pulse
);
    localparam int W   = DATA_BYTES * 8;
    localparam int AW  = ADDR_BYTES * 8;
    localparam int OFF = $clog2(DATA_BYTES);
    localparam int IW  = AW + 1;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {COLLECT, COMMIT, RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_t;

    wstate_t           wstate;
    rstate_t           rstate;

    logic              aw_held;
    logic              w_held;
    logic [AW-1:0]     aw_addr_q;
    logic [W-1:0]      w_data_q;
    logic [DATA_BYTES-1:0] w_strb_q;
    logic              awready;
    logic              wready;
    logic              bvalid;
    logic [1:0]        bresp;

    logic [AW-1:0]     ar_addr_q;
    logic              arready;
    logic              rvalid;
    logic [W-1:0]      rdata;
    logic [1:0]        rresp;

    logic              aw_hs;
    logic              w_hs;
    logic              ar_hs;
    logic              aw_take;
    logic              w_take;
    logic [AW-1:0]     w_idx;
    logic [AW-1:0]     r_idx;
    logic              w_hit;
    logic              r_hit;
    logic [W-1:0]      r_word;
    logic              unused;

    assign bus.awready = awready;
    assign bus.wready  = wready;
    assign bus.bvalid  = bvalid;
    assign bus.bresp   = bresp;
    assign bus.arready = arready;
    assign bus.rvalid  = rvalid;
    assign bus.rdata   = rdata;
    assign bus.rresp   = rresp;

    assign unused = ^{bus.awprot, bus.arprot};

    assign aw_hs   = bus.awvalid && awready;
    assign w_hs    = bus.wvalid && wready;
    assign ar_hs   = bus.arvalid && arready;
    assign aw_take = aw_held || aw_hs;
    assign w_take  = w_held || w_hs;

    // Word index; sub-word address bits are dropped.
    assign w_idx = aw_addr_q >> OFF;
    assign r_idx = ar_addr_q >> OFF;
    assign w_hit = {1'b0, w_idx} < IW'(NUM_REGS);
    assign r_hit = {1'b0, r_idx} < IW'(NUM_REGS);

    always_comb begin
        r_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if ({1'b0, r_idx} == IW'(i)) begin
                r_word = reg_q[i*W +: W];
            end
        end
    end

    // Write engine: one outstanding write, AW and W may arrive in any order.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wstate    <= COLLECT;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            awready   <= 1'b0;
            wready    <= 1'b0;
            bvalid    <= 1'b0;
            bresp     <= OKAY;
            wr_pulse  <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                reg_q[i*W +: W] <= RESET_VALUE;
            end
        end else begin
            wr_pulse <= '0;
            unique case (wstate)
                COLLECT: begin
                    if (aw_hs) begin
                        aw_addr_q <= bus.awaddr;
                    end
                    if (w_hs) begin
                        w_data_q <= bus.wdata;
                        w_strb_q <= bus.wstrb;
                    end
                    aw_held <= aw_take;
                    w_held  <= w_take;
                    if (aw_take && w_take) begin
                        awready <= 1'b0;
                        wready  <= 1'b0;
                        wstate  <= COMMIT;
                    end else begin
                        awready <= !aw_take;
                        wready  <= !w_take;
                    end
                end
                COMMIT: begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (w_hit && {1'b0, w_idx} == IW'(i)) begin
                            wr_pulse[i] <= 1'b1;
                            for (int b = 0; b < DATA_BYTES; b++) begin
                                if (w_strb_q[b]) begin
                                    reg_q[i*W + b*8 +: 8] <= w_data_q[b*8 +: 8];
                                end
                            end
                        end
                    end
                    bvalid <= 1'b1;
                    bresp  <= w_hit ? OKAY : SLVERR;
                    wstate <= RESP;
                end
                RESP: begin
                    if (bus.bready) begin
                        bvalid  <= 1'b0;
                        aw_held <= 1'b0;
                        w_held  <= 1'b0;
                        awready <= 1'b1;
                        wready  <= 1'b1;
                        wstate  <= COLLECT;
                    end
                end
                default: wstate <= COLLECT;
            endcase
        end
    end

    // Read engine: data is sampled one edge after the AR handshake,
    // so a write committing on that same edge is not yet visible.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rstate    <= R_IDLE;
            ar_addr_q <= '0;
            arready   <= 1'b0;
            rvalid    <= 1'b0;
            rdata     <= '0;
            rresp     <= OKAY;
        end else begin
            unique case (rstate)
                R_IDLE: begin
                    if (ar_hs) begin
                        ar_addr_q <= bus.araddr;
                        arready   <= 1'b0;
                        rstate    <= R_FETCH;
                    end else begin
                        arready   <= 1'b1;
                    end
                end
                R_FETCH: begin
                    rvalid <= 1'b1;
                    rdata  <= r_hit ? r_word : '0;
                    rresp  <= r_hit ? OKAY : SLVERR;
                    rstate <= R_DATA;
                end
                R_DATA: begin
                    if (bus.rready) begin
                        rvalid  <= 1'b0;
                        arready <= 1'b1;
                        rstate  <= R_IDLE;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi4_lite_regfile_slave.sv
// Directed bench for the AXI4-Lite register file slave.
// Ports: none; drives the DUT through the bus interface.
module tb_axi4_lite_regfile_slave;
    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [511:0]  reg_q;
    logic [15:0]   wr_pulse;
    int            total = 0;
    int            bad = 0;
    int            pulses [16] = '{default: 0};

    axi4_lite_regfile_slave_if #(.ADDR_BYTES(1), .DATA_BYTES(4)) bus();

    axi4_lite_regfile_slave #(
        .DATA_BYTES(4),
        .ADDR_BYTES(1),
        .NUM_REGS(16),
        .RESET_VALUE(32'h0)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .bus(bus.slave),
        .reg_q(reg_q),
        .wr_pulse(wr_pulse)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) begin
        for (int i = 0; i < 16; i++) begin
            if (wr_pulse[i]) pulses[i]++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d,
                             input logic [3:0] s, input int lead,
                             input int bdelay, output logic [1:0] resp);
        bit aw_done = 0;
        bit w_done = 0;
        bit aw_hs;
        bit w_hs;
        int c = 0;
        bus.awaddr = a;
        bus.awprot = 3'b000;
        bus.wdata  = d;
        bus.wstrb  = s;
        while (!(aw_done && w_done) && c < 20) begin
            bus.awvalid = !aw_done && (c >= lead);
            bus.wvalid  = !w_done;
            aw_hs = bus.awvalid && bus.awready;
            w_hs  = bus.wvalid && bus.wready;
            @(posedge aclk); #1;
            c++;
            if (aw_hs) aw_done = 1;
            if (w_hs) w_done = 1;
        end
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        check("aw_w_accept", {aw_done, w_done}, 2'b11);
        @(posedge aclk); #1;
        check("b_latency", bus.bvalid, 1'b1);
        resp = bus.bresp;
        for (int i = 0; i < bdelay; i++) begin
            @(posedge aclk); #1;
            check("b_hold", {bus.bvalid, bus.bresp}, {1'b1, resp});
            check("aw_w_blocked", {bus.awready, bus.wready}, 2'b00);
        end
        bus.bready = 1'b1;
        @(posedge aclk); #1;
        bus.bready = 1'b0;
        check("b_drop", bus.bvalid, 1'b0);
    endtask

    task automatic axi_read(input logic [7:0] a, output logic [31:0] d,
                            output logic [1:0] resp);
        bit done = 0;
        bit hs;
        int c = 0;
        bus.araddr = a;
        bus.arprot = 3'b000;
        while (!done && c < 20) begin
            bus.arvalid = 1'b1;
            hs = bus.arready;
            @(posedge aclk); #1;
            c++;
            done = hs;
        end
        bus.arvalid = 1'b0;
        check("ar_accept", done, 1'b1);
        @(posedge aclk); #1;
        check("r_latency", bus.rvalid, 1'b1);
        d = bus.rdata;
        resp = bus.rresp;
        bus.rready = 1'b1;
        @(posedge aclk); #1;
        bus.rready = 1'b0;
        check("r_drop", bus.rvalid, 1'b0);
    endtask

    initial begin
        logic [1:0]  br;
        logic [1:0]  rr;
        logic [31:0] rd;
        int          p0;
        int          psum;

        bus.awvalid = 0; bus.awaddr = 0; bus.awprot = 0;
        bus.wvalid = 0;  bus.wdata = 0;  bus.wstrb = 0;
        bus.bready = 0;
        bus.arvalid = 0; bus.araddr = 0; bus.arprot = 0;
        bus.rready = 0;

        // reset state
        repeat (2) @(posedge aclk);
        #1;
        check("rst_readys", {bus.awready, bus.wready, bus.arready}, 3'b000);
        check("rst_valids", {bus.bvalid, bus.rvalid}, 2'b00);
        check("rst_resp", {bus.bresp, bus.rresp}, 4'h0);
        check("rst_rdata", bus.rdata, 32'h0);
        check("rst_regs", |reg_q, 1'b0);
        aresetn = 1'b1;
        check("rst_ready_wait", bus.awready, 1'b0);
        @(posedge aclk); #1;
        check("ready_rise", {bus.awready, bus.wready, bus.arready}, 3'b111);

        // 1: full-word write and read back
        p0 = pulses[1];
        axi_write(8'h04, 32'hDEADBEEF, 4'hF, 0, 0, br);
        check("t1_bresp", br, 2'b00);
        axi_read(8'h04, rd, rr);
        check("t1_rdata", rd, 32'hDEADBEEF);
        check("t1_rresp", rr, 2'b00);
        check("t1_pulse", pulses[1] - p0, 1);

        // 2: partial strobe
        axi_write(8'h04, 32'hCAFEFEED, 4'b0011, 0, 0, br);
        check("t2_bresp", br, 2'b00);
        axi_read(8'h04, rd, rr);
        check("t2_rdata", rd, 32'hDEADFEED);

        // 3: W three cycles ahead of AW
        p0 = pulses[2];
        axi_write(8'h08, 32'hDEC0DED3, 4'hF, 3, 0, br);
        check("t3_bresp", br, 2'b00);
        check("t3_pulse", pulses[2] - p0, 1);
        check("t3_reg2", reg_q[2*32 +: 32], 32'hDEC0DED3);

        // 4: out-of-range address
        psum = 0;
        for (int i = 0; i < 16; i++) psum += pulses[i];
        axi_write(8'hC4, 32'h55AA55AA, 4'hF, 0, 0, br);
        check("t4_bresp", br, 2'b10);
        axi_read(8'hC4, rd, rr);
        check("t4_rresp", rr, 2'b10);
        check("t4_rdata", rd, 32'h0);
        for (int i = 0; i < 16; i++) psum -= pulses[i];
        check("t4_no_pulse", psum, 0);
        check("t4_reg1", reg_q[1*32 +: 32], 32'hDEADFEED);
        check("t4_reg2", reg_q[2*32 +: 32], 32'hDEC0DED3);

        // 5: stalled B with a concurrent read
        fork
            begin
                logic [1:0] wb;
                axi_write(8'h0C, 32'h12345678, 4'hF, 0, 5, wb);
                check("t5_bresp", wb, 2'b00);
            end
            begin
                logic [31:0] d5;
                logic [1:0]  r5;
                axi_read(8'h00, d5, r5);
                check("t5_rdata", d5, 32'h0);
                check("t5_rresp", r5, 2'b00);
            end
        join
        axi_read(8'h0E, rd, rr);
        check("t5_lowbits", rd, 32'h12345678);

        // zero strobe still pulses but changes nothing
        p0 = pulses[3];
        axi_write(8'h0C, 32'hFFFFFFFF, 4'h0, 0, 0, br);
        check("zs_bresp", br, 2'b00);
        check("zs_pulse", pulses[3] - p0, 1);
        check("zs_reg3", reg_q[3*32 +: 32], 32'h12345678);

        // 6: reset while in RESP and R_DATA
        bus.awaddr = 8'h04; bus.wdata = 32'h11111111; bus.wstrb = 4'hF;
        bus.araddr = 8'h08;
        bus.awvalid = 1; bus.wvalid = 1; bus.arvalid = 1;
        @(posedge aclk); #1;
        bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
        @(posedge aclk); #1;
        check("t6_bvalid", bus.bvalid, 1'b1);
        check("t6_rvalid", bus.rvalid, 1'b1);
        check("t6_rdata", bus.rdata, 32'hDEC0DED3);
        check("t6_reg1", reg_q[1*32 +: 32], 32'h11111111);
        #2;
        aresetn = 1'b0;
        #1;
        check("t6_valids", {bus.bvalid, bus.rvalid}, 2'b00);
        check("t6_readys", {bus.awready, bus.wready, bus.arready}, 3'b000);
        check("t6_regs", |reg_q, 1'b0);
        check("t6_pulse", wr_pulse, 16'h0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk); #1;
        check("t6_ready_rise", {bus.awready, bus.wready, bus.arready}, 3'b111);
        axi_write(8'h10, 32'hABCD0123, 4'hF, 0, 0, br);
        check("t6_bresp", br, 2'b00);
        axi_read(8'h04, rd, rr);
        check("t6_rst_val", rd, 32'h0);
        axi_read(8'h10, rd, rr);
        check("t6_new_val", rd, 32'hABCD0123);
        check("t6_rresp", rr, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
